// File: rtl/collatz_sweep_driver.sv
// collatz_sweep_driver: issues operands to a valid/ready compute block and
// collects its results, in manual, timed auto-step, single-step or sweep mode.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no request outstanding; evaluates the active mode each cycle
// ISSUE | dut_in_valid high, operand held until dut_in_ready is seen
// WAIT  | request accepted (busy), waiting for the result handshake
// HALT  | sweep finished; waits for a btn edge or a mode change
module collatz_sweep_driver #(
    parameter int W     = 27,
    parameter int SW    = 15,
    parameter int DIV_W = 27,
    parameter int SHIFT = 12
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic [1:0]    mode,
    input  logic [SW-1:0] sw,
    input  logic          btn,
    output logic          dut_in_valid,
    input  logic          dut_in_ready,
    output logic [W-1:0]  dut_in0,
    input  logic          dut_out_valid,
    output logic          dut_out_ready,
    input  logic [W-1:0]  dut_out0,
    output logic [SW:0]   disp,
    output logic [W-1:0]  max_res,
    output logic [W-1:0]  max_arg,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_MANUAL = 2'd0;
    localparam logic [1:0] MODE_AUTO   = 2'd1;
    localparam logic [1:0] MODE_SINGLE = 2'd2;
    localparam logic [1:0] MODE_SWEEP  = 2'd3;

    state_t             state, state_nxt;
    logic [W-1:0]       operand;
    logic               busy;
    logic [DIV_W-1:0]   counter;
    logic [SW-1:0]      disp_low;
    logic               btn_q;
    logic [1:0]         act_mode;
    logic               sweeping;

    logic               in_acc, out_acc, btn_edge, mode_chg, cnt_hit;
    logic [W-1:0]       limit;
    logic               op_load_sw, op_inc, sweep_start, sweep_end;
    logic               cnt_clr, cnt_inc, mode_latch, max_upd;

    // The active mode only follows the mode input while no request is in flight,
    // so an outstanding transaction always finishes under the old behaviour.
    assign in_acc   = dut_in_valid & dut_in_ready;
    assign out_acc  = dut_out_valid & busy;
    assign btn_edge = btn & ~btn_q;
    assign mode_chg = (mode != act_mode);
    assign limit    = W'(sw);
    assign cnt_hit  = (counter[DIV_W-1:SHIFT] == (DIV_W-SHIFT)'(sw));

    assign dut_in_valid  = (state == ISSUE);
    assign dut_in0       = operand;
    assign dut_out_ready = busy;
    assign disp          = {busy, disp_low};

    // State register.
    always_ff @(posedge clk) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode and datapath strobes.
    always_comb begin
        state_nxt   = state;
        op_load_sw  = 1'b0;
        op_inc      = 1'b0;
        sweep_start = 1'b0;
        sweep_end   = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        mode_latch  = 1'b0;
        max_upd     = 1'b0;
        case (state)
            IDLE: begin
                if (mode_chg) begin
                    mode_latch = 1'b1;
                    cnt_clr    = 1'b1;
                end else begin
                    case (act_mode)
                        MODE_MANUAL: begin
                            if (limit != operand) begin
                                op_load_sw = 1'b1;
                                state_nxt  = ISSUE;
                            end
                        end
                        MODE_AUTO: begin
                            if (cnt_hit) begin
                                op_inc    = 1'b1;
                                cnt_clr   = 1'b1;
                                state_nxt = ISSUE;
                            end else begin
                                cnt_inc = 1'b1;
                            end
                        end
                        MODE_SINGLE: begin
                            if (btn_edge) begin
                                op_inc    = 1'b1;
                                state_nxt = ISSUE;
                            end
                        end
                        MODE_SWEEP: begin
                            if (btn_edge) begin
                                sweep_start = 1'b1;
                                state_nxt   = ISSUE;
                            end else if (sweeping) begin
                                op_inc    = 1'b1;
                                state_nxt = ISSUE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ISSUE: begin
                if (dut_in_ready) state_nxt = WAIT;
            end
            WAIT: begin
                if (out_acc) begin
                    if (act_mode == MODE_SWEEP && sweeping) begin
                        max_upd = (dut_out0 > max_res);
                        // >= so a limit of 0 or 1 still ends after the single issue of 1
                        if (operand >= limit) begin
                            sweep_end = 1'b1;
                            state_nxt = HALT;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            HALT: begin
                if (mode_chg) begin
                    state_nxt = IDLE;
                end else if (btn_edge) begin
                    sweep_start = 1'b1;
                    state_nxt   = ISSUE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand, timer, handshake, display and sweep bookkeeping registers.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            operand  <= '0;
            busy     <= 1'b0;
            counter  <= '0;
            disp_low <= '0;
            btn_q    <= 1'b0;
            act_mode <= MODE_MANUAL;
            sweeping <= 1'b0;
            max_res  <= '0;
            max_arg  <= '0;
            done     <= 1'b0;
        end else begin
            btn_q <= btn;

            if (mode_latch) begin
                act_mode <= mode;
                sweeping <= 1'b0;
            end

            if (cnt_clr)      counter <= '0;
            else if (cnt_inc) counter <= counter + DIV_W'(1);

            if (in_acc)       busy <= 1'b1;
            else if (out_acc) busy <= 1'b0;

            if (out_acc) disp_low <= dut_out0[SW-1:0];

            if (sweep_start) begin
                operand  <= W'(1);
                max_res  <= '0;
                max_arg  <= '0;
                done     <= 1'b0;
                sweeping <= 1'b1;
            end else begin
                if (op_load_sw)  operand <= limit;
                else if (op_inc) operand <= operand + W'(1);
                if (max_upd) begin
                    max_res <= dut_out0;
                    max_arg <= operand;
                end
                if (sweep_end) begin
                    done     <= 1'b1;
                    sweeping <= 1'b0;
                end
            end
        end
    end

endmodule
